// File: rtl/argmin_stream.sv
// argmin_stream: pipelined argmin over a cost vector that arrives as BEATS beats of INPUTS
// packed WIDTH-bit words. Each comparator-tree level is one register stage. A global-index
// stage follows the tree, then a running-minimum accumulator merges beats. The last beat of a
// search writes the merged result to the output registers.
//
// Optional feature: define ARGMIN_SECOND_MIN_EN to add the second_value port and its logic.
// second_value is the second-smallest cost over all candidates. Duplicates count, so two
// equal minima give second_value == min_value.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   beat present
//   in_ready     out  beat accepted this cycle when in_valid is high
//   in_words     in   packed beat, word k at [WIDTH*k +: WIDTH]
//   out_valid    out  result present, held until out_ready
//   out_ready    in   consumer takes the result
//   min_value    out  minimum cost of the search
//   min_index    out  global index of the minimum (beat*INPUTS + word)
//   second_value out  second-smallest cost (ARGMIN_SECOND_MIN_EN only)
//
// Latency: out_valid rises LEVELS+1 cycles after the last beat's handshake.
// Throughput: one beat per cycle.
module argmin_stream #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned INPUTS = 8,
  parameter int unsigned BEATS  = 4,
  localparam int unsigned N_CAND     = INPUTS * BEATS,
  localparam int unsigned INDEX_BITS = (N_CAND > 1) ? $clog2(N_CAND) : 1,
  localparam int unsigned LEVELS     = $clog2(INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUTS*WIDTH-1:0] in_words,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        min_value,
  output logic [INDEX_BITS-1:0]   min_index
`ifdef ARGMIN_SECOND_MIN_EN
  ,
  output logic [WIDTH-1:0]        second_value
`endif
);

  localparam int unsigned BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (WIDTH == 0 || INPUTS < 2 || (INPUTS & (INPUTS - 1)) != 0 || BEATS < 1) begin : g_param_check
    $error("argmin_stream: WIDTH must be > 0, INPUTS a power of two >= 2, BEATS >= 1");
  end

  // One tree node: value, local (in-beat) index and optionally the runner-up value.
  typedef struct packed {
    logic [WIDTH-1:0]  val;
    logic [LEVELS-1:0] idx;
`ifdef ARGMIN_SECOND_MIN_EN
    logic [WIDTH-1:0]  sec;
`endif
  } node_t;

`ifdef ARGMIN_SECOND_MIN_EN
  function automatic logic [WIDTH-1:0] min2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b < a) ? b : a;
  endfunction
`endif

  // a holds the lower indices, so a wins ties.
  function automatic node_t merge_node(input node_t a, input node_t b);
    node_t r;
    logic  b_wins;
    b_wins = b.val < a.val;
    r      = b_wins ? b : a;
`ifdef ARGMIN_SECOND_MIN_EN
    r.sec  = b_wins ? min2(a.val, b.sec) : min2(b.val, a.sec);
`endif
    return r;
  endfunction

  logic stall;
  logic advance;

  // Beat counter and tags.
  logic [BEAT_BITS-1:0] beat_cnt_q;
  logic                 beat_first;
  logic                 beat_last;

  // Heap-ordered tree: node n has children 2n and 2n+1. Nodes 1..INPUTS-1 are registers,
  // INPUTS..2*INPUTS-1 are the incoming words. Node n sits at level LEVELS-floor(log2 n),
  // so every level is exactly one register stage when all nodes load together.
  node_t node [2*INPUTS];
  node_t tree_q [INPUTS];

  // Tags travelling beside the tree; stage s holds level s+1.
  logic [LEVELS-1:0]    lvl_valid_q;
  logic [LEVELS-1:0]    lvl_first_q;
  logic [LEVELS-1:0]    lvl_last_q;
  logic [BEAT_BITS-1:0] lvl_beat_q [LEVELS];

  // Global-index stage.
  logic                  g_valid_q;
  logic                  g_first_q;
  logic                  g_last_q;
  logic [WIDTH-1:0]      g_val_q;
  logic [INDEX_BITS-1:0] g_idx_q;
  logic [INDEX_BITS-1:0] root_gidx;

  // Accumulator and merged result.
  logic [WIDTH-1:0]      acc_val_q;
  logic [INDEX_BITS-1:0] acc_idx_q;
  logic                  take_new;
  logic [WIDTH-1:0]      m_val;
  logic [INDEX_BITS-1:0] m_idx;

  // Output registers.
  logic                  out_valid_q;
  logic [WIDTH-1:0]      out_val_q;
  logic [INDEX_BITS-1:0] out_idx_q;

`ifdef ARGMIN_SECOND_MIN_EN
  logic [WIDTH-1:0] g_sec_q;
  logic [WIDTH-1:0] acc_sec_q;
  logic [WIDTH-1:0] m_sec;
  logic [WIDTH-1:0] out_sec_q;
`endif

  // Only a held, unconsumed result blocks the pipe; everything advances in lockstep.
  assign stall    = out_valid_q & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;

  assign beat_first = (beat_cnt_q == '0);
  assign beat_last  = (beat_cnt_q == BEAT_BITS'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (in_valid && in_ready) begin
      beat_cnt_q <= beat_last ? '0 : beat_cnt_q + 1'b1;
    end
  end

  always_comb begin
    node_t leaf;
    node[0] = '0;
    for (int unsigned n = 1; n < INPUTS; n++) begin
      node[n] = tree_q[n];
    end
    for (int unsigned k = 0; k < INPUTS; k++) begin
      leaf     = '1;  // leaf runner-up is all ones
      leaf.val = in_words[WIDTH*k +: WIDTH];
      leaf.idx = LEVELS'(k);
      node[INPUTS+k] = leaf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < INPUTS; n++) begin
        tree_q[n] <= '0;
      end
    end else if (advance) begin
      for (int unsigned n = 1; n < INPUTS; n++) begin
        tree_q[n] <= merge_node(node[2*n], node[2*n+1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_valid_q <= '0;
      lvl_first_q <= '0;
      lvl_last_q  <= '0;
      for (int unsigned s = 0; s < LEVELS; s++) begin
        lvl_beat_q[s] <= '0;
      end
    end else if (advance) begin
      lvl_valid_q[0] <= in_valid;
      lvl_first_q[0] <= beat_first;
      lvl_last_q[0]  <= beat_last;
      lvl_beat_q[0]  <= beat_cnt_q;
      for (int unsigned s = 1; s < LEVELS; s++) begin
        lvl_valid_q[s] <= lvl_valid_q[s-1];
        lvl_first_q[s] <= lvl_first_q[s-1];
        lvl_last_q[s]  <= lvl_last_q[s-1];
        lvl_beat_q[s]  <= lvl_beat_q[s-1];
      end
    end
  end

  // Global index of the tree winner; BEATS need not be a power of two, so multiply.
  assign root_gidx = INDEX_BITS'(32'(lvl_beat_q[LEVELS-1]) * 32'(INPUTS) + 32'(tree_q[1].idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_valid_q <= 1'b0;
      g_first_q <= 1'b0;
      g_last_q  <= 1'b0;
      g_val_q   <= '0;
      g_idx_q   <= '0;
`ifdef ARGMIN_SECOND_MIN_EN
      g_sec_q   <= '0;
`endif
    end else if (advance) begin
      g_valid_q <= lvl_valid_q[LEVELS-1];
      g_first_q <= lvl_first_q[LEVELS-1];
      g_last_q  <= lvl_last_q[LEVELS-1];
      g_val_q   <= tree_q[1].val;
      g_idx_q   <= root_gidx;
`ifdef ARGMIN_SECOND_MIN_EN
      g_sec_q   <= tree_q[1].sec;
`endif
    end
  end

  // Merge the beat result into the running minimum; the earlier beat keeps ties.
  always_comb begin
    take_new = g_first_q | (g_val_q < acc_val_q);
    m_val    = take_new ? g_val_q : acc_val_q;
    m_idx    = take_new ? g_idx_q : acc_idx_q;
`ifdef ARGMIN_SECOND_MIN_EN
    if (g_first_q) begin
      m_sec = g_sec_q;
    end else if (g_val_q < acc_val_q) begin
      m_sec = min2(acc_val_q, g_sec_q);
    end else begin
      m_sec = min2(g_val_q, acc_sec_q);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_val_q   <= '0;
      acc_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_val_q   <= '0;
      out_idx_q   <= '0;
`ifdef ARGMIN_SECOND_MIN_EN
      acc_sec_q   <= '0;
      out_sec_q   <= '0;
`endif
    end else if (advance) begin
      // Not stalled means any held result is being consumed this cycle.
      out_valid_q <= g_valid_q & g_last_q;
      if (g_valid_q) begin
        acc_val_q <= m_val;
        acc_idx_q <= m_idx;
`ifdef ARGMIN_SECOND_MIN_EN
        acc_sec_q <= m_sec;
`endif
      end
      if (g_valid_q && g_last_q) begin
        out_val_q <= m_val;
        out_idx_q <= m_idx;
`ifdef ARGMIN_SECOND_MIN_EN
        out_sec_q <= m_sec;
`endif
      end
    end
  end

  assign out_valid = out_valid_q;
  assign min_value = out_val_q;
  assign min_index = out_idx_q;
`ifdef ARGMIN_SECOND_MIN_EN
  assign second_value = out_sec_q;
`endif

endmodule
